// File: rtl/wb_pkg.sv
// Shared types and constants for the register writeback block.
package wb_pkg;
   localparam int W_DEF      = 8;
   localparam int D_DEF      = 4;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [1:0] {IDLE, IMM_SET, IMM_DATA} wb_state_e;
endpackage

// File: rtl/reg_writeback_if.sv
// Handshake and register-file bus of reg_writeback; WB_FWD_EN adds the forwarding lookup signals.
interface reg_writeback_if import wb_pkg::*; #(
   parameter int W = W_DEF,
   parameter int D = D_DEF
);
   logic           AluValid, AluReady;
   logic [D-1:0]   AluAddr;
   logic [W-1:0]   AluData;
   logic           MemValid, MemReady;
   logic [D-1:0]   MemAddr;
   logic [W-1:0]   MemData;
   logic           ImmValid, ImmReady;
   logic [D-1:0]   ImmAddr;
   logic [W-1:0]   ImmData;
   logic           RfWriteEn, RfRegSet;
   logic [D-1:0]   RfWaddr, RfRaddrB;
   logic [W-1:0]   RfDataIn;
   logic [2**D-1:0] Pending;
`ifdef WB_FWD_EN
   logic [D-1:0]   FwdAddr;
   logic           FwdHit;
   logic [W-1:0]   FwdData;
`endif

   modport master (
      output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ImmValid, ImmAddr, ImmData,
      input  AluReady, MemReady, ImmReady, RfWriteEn, RfRegSet, RfWaddr, RfRaddrB, RfDataIn, Pending
`ifdef WB_FWD_EN
      , output FwdAddr, input FwdHit, FwdData
`endif
   );

   modport slave (
      input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ImmValid, ImmAddr, ImmData,
      output AluReady, MemReady, ImmReady, RfWriteEn, RfRegSet, RfWaddr, RfRaddrB, RfDataIn, Pending
`ifdef WB_FWD_EN
      , input FwdAddr, output FwdHit, FwdData
`endif
   );
endinterface

// File: rtl/wb_fifo.sv
// Two-entry queue for memory-load returns; slot 0 is always the head (oldest).
module wb_fifo import wb_pkg::*; #(
   parameter int W = W_DEF,
   parameter int D = D_DEF
) (
   input  logic                             Clk,
   input  logic                             clr,
   input  logic                             push,
   input  logic [D-1:0]                     push_addr,
   input  logic [W-1:0]                     push_data,
   input  logic                             pop,
   output logic                             full,
   output logic                             empty,
   output logic [FIFO_DEPTH-1:0]            vld,
   output logic [FIFO_DEPTH-1:0][D-1:0]     addr,
   output logic [FIFO_DEPTH-1:0][W-1:0]     data
);
   always_ff @(posedge Clk) begin
      if (clr) begin
         vld <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (vld[0]) begin
                  addr[1] <= push_addr;
                  data[1] <= push_data;
                  vld[1]  <= 1'b1;
               end else begin
                  addr[0] <= push_addr;
                  data[0] <= push_data;
                  vld[0]  <= 1'b1;
               end
            end
            2'b01: begin
               addr[0] <= addr[1];
               data[0] <= data[1];
               vld     <= {1'b0, vld[1]};
            end
            2'b11: begin
               // occupancy is unchanged: the new entry lands behind whatever survives the pop
               if (vld[1]) begin
                  addr[0] <= addr[1];
                  data[0] <= data[1];
                  addr[1] <= push_addr;
                  data[1] <= push_data;
               end else begin
                  addr[0] <= push_addr;
                  data[0] <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign full  = vld[1];
   assign empty = !vld[0];
endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: queued memory returns, two-cycle immediate loads and ALU results.
// Optional macro WB_FWD_EN adds a combinational forwarding lookup over pending writes.
module reg_writeback import wb_pkg::*; #(
   parameter int W = W_DEF,
   parameter int D = D_DEF
) (
   input logic            Clk,
   input logic            Reset,
   input logic            Start,
   reg_writeback_if.slave bus
);
   logic                          flush;
   wb_state_e                     state_q, state_d;
   logic                          fifo_full, fifo_empty;
   logic [FIFO_DEPTH-1:0]         fifo_vld;
   logic [FIFO_DEPTH-1:0][D-1:0]  fifo_addr;
   logic [FIFO_DEPTH-1:0][W-1:0]  fifo_data;
   logic                          mem_ready, imm_ready, alu_ready, pop;
   logic                          mem_push, imm_xfer, alu_xfer;
   logic                          wr_en_q, reg_set_q;
   logic [D-1:0]                  waddr_q, raddr_b_q;
   logic [W-1:0]                  data_in_q, imm_data_q;
   logic [2**D-1:0]               pending;

   assign flush = Reset | Start;

   wb_fifo #(.W(W), .D(D)) u_fifo (
      .Clk       (Clk),
      .clr       (flush),
      .push      (mem_push),
      .push_addr (bus.MemAddr),
      .push_data (bus.MemData),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .vld       (fifo_vld),
      .addr      (fifo_addr),
      .data      (fifo_data)
   );

   always_ff @(posedge Clk) begin
      if (flush) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (imm_xfer) state_d = IMM_SET;
         IMM_SET:  state_d = IMM_DATA;
         IMM_DATA: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Queued memory returns win over new Imm/ALU work so loads never starve
   always_comb begin
      mem_ready = !fifo_full && !flush;
      imm_ready = 1'b0;
      alu_ready = 1'b0;
      pop       = 1'b0;
      if (state_q == IDLE && !flush) begin
         pop       = !fifo_empty;
         imm_ready = fifo_empty;
         alu_ready = fifo_empty && !bus.ImmValid;
      end
   end

   assign mem_push = bus.MemValid && mem_ready;
   assign imm_xfer = bus.ImmValid && imm_ready;
   assign alu_xfer = bus.AluValid && alu_ready;

   always_ff @(posedge Clk) begin
      if (flush) begin
         wr_en_q    <= 1'b0;
         reg_set_q  <= 1'b0;
         waddr_q    <= '0;
         raddr_b_q  <= '0;
         data_in_q  <= '0;
         imm_data_q <= '0;
      end else begin
         wr_en_q   <= pop || alu_xfer;
         reg_set_q <= imm_xfer;
         if (pop)           waddr_q <= fifo_addr[0];
         else if (alu_xfer) waddr_q <= bus.AluAddr;
         if (imm_xfer) begin
            raddr_b_q  <= bus.ImmAddr;
            imm_data_q <= bus.ImmData;
         end
         if (pop)                     data_in_q <= fifo_data[0];
         else if (alu_xfer)           data_in_q <= bus.AluData;
         else if (state_q == IMM_SET) data_in_q <= imm_data_q;
         else                         data_in_q <= '0;
      end
   end

   // A write is pending from its acceptance cycle until its data reaches the register file
   always_comb begin
      pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (fifo_vld[i]) pending[fifo_addr[i]] = 1'b1;
      if (mem_push)             pending[bus.MemAddr] = 1'b1;
      if (alu_xfer)             pending[bus.AluAddr] = 1'b1;
      if (imm_xfer)             pending[bus.ImmAddr] = 1'b1;
      if (state_q == IMM_SET)   pending[raddr_b_q]   = 1'b1;
   end

   assign bus.AluReady  = alu_ready;
   assign bus.ImmReady  = imm_ready;
   assign bus.MemReady  = mem_ready;
   assign bus.RfWriteEn = wr_en_q;
   assign bus.RfRegSet  = reg_set_q;
   assign bus.RfWaddr   = waddr_q;
   assign bus.RfRaddrB  = raddr_b_q;
   assign bus.RfDataIn  = data_in_q;
   assign bus.Pending   = pending;

`ifdef WB_FWD_EN
   logic         fwd_hit;
   logic [W-1:0] fwd_data;

   // Sources are visited oldest first so the youngest match is what remains
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (alu_xfer && bus.AluAddr == bus.FwdAddr) begin
         fwd_hit = 1'b1; fwd_data = bus.AluData;
      end
      if (state_q == IMM_SET && raddr_b_q == bus.FwdAddr) begin
         fwd_hit = 1'b1; fwd_data = imm_data_q;
      end
      if (imm_xfer && bus.ImmAddr == bus.FwdAddr) begin
         fwd_hit = 1'b1; fwd_data = bus.ImmData;
      end
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (fifo_vld[i] && fifo_addr[i] == bus.FwdAddr) begin
            fwd_hit = 1'b1; fwd_data = fifo_data[i];
         end
      if (mem_push && bus.MemAddr == bus.FwdAddr) begin
         fwd_hit = 1'b1; fwd_data = bus.MemData;
      end
   end

   assign bus.FwdHit  = fwd_hit;
   assign bus.FwdData = fwd_data;
`else
   // Tail data only feeds the forwarding lookup
   logic unused_tail;
   assign unused_tail = ^fifo_data[FIFO_DEPTH-1];
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected register writes are queued as stimulus is driven and
// matched as the DUT issues them; handshake/state outputs are checked cycle by cycle.
`timescale 1ns/1ps
module tb_reg_writeback;
   localparam int W = 8;
   localparam int D = 4;

   typedef struct {
      logic [D-1:0] addr;
      logic [W-1:0] data;
   } wr_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   logic Start = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   wr_t  sb[$];

   reg_writeback_if #(.W(W), .D(D)) bus ();

   reg_writeback #(.W(W), .D(D)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_wr(input logic [D-1:0] a, input logic [W-1:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   // Any issued write must match the oldest outstanding expectation
   task automatic mon();
      wr_t e;
      if (bus.RfWriteEn === 1'b1) begin
         if (sb.size() == 0) begin
            chk("wr_unexpected", bus.RfWriteEn, 0);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", bus.RfWaddr, e.addr);
            chk("wr_data", bus.RfDataIn, e.data);
         end
      end
   endtask

   task automatic tick();
      @(negedge Clk);
      mon();
   endtask

   task automatic nxt();
      @(posedge Clk);
      #1;
   endtask

   task automatic alu(input logic v, input logic [D-1:0] a, input logic [W-1:0] d);
      bus.AluValid = v; bus.AluAddr = a; bus.AluData = d;
   endtask

   task automatic mem(input logic v, input logic [D-1:0] a, input logic [W-1:0] d);
      bus.MemValid = v; bus.MemAddr = a; bus.MemData = d;
   endtask

   task automatic imm(input logic v, input logic [D-1:0] a, input logic [W-1:0] d);
      bus.ImmValid = v; bus.ImmAddr = a; bus.ImmData = d;
   endtask

   initial begin
      alu(0, 0, 0);
      mem(0, 0, 0);
      imm(0, 0, 0);
`ifdef WB_FWD_EN
      bus.FwdAddr = '0;
`endif
      nxt(); nxt();

      // reset held: no handshake may be offered
      tick();
      chk("rst_alu_rdy", bus.AluReady, 0);
      chk("rst_imm_rdy", bus.ImmReady, 0);
      chk("rst_mem_rdy", bus.MemReady, 0);
      nxt(); Reset = 1'b0;
      tick();
      chk("rst_wen",    bus.RfWriteEn, 0);
      chk("rst_regset", bus.RfRegSet, 0);
      chk("rst_waddr",  bus.RfWaddr, 0);
      chk("rst_raddrb", bus.RfRaddrB, 0);
      chk("rst_data",   bus.RfDataIn, 0);
      chk("rst_pend",   bus.Pending, 0);
      chk("idle_alu_rdy", bus.AluReady, 1);
      chk("idle_mem_rdy", bus.MemReady, 1);
      nxt();

      // ALU write, one-cycle latency
      alu(1, 4'd3, 8'h5A); exp_wr(4'd3, 8'h5A);
      tick();
      chk("a_rdy",      bus.AluReady, 1);
      chk("a_pend_acc", bus.Pending, 16'h0008);
      nxt(); alu(0, 0, 0);
      tick();
      chk("a_wen",       bus.RfWriteEn, 1);
      chk("a_pend_done", bus.Pending, 0);
      nxt();
      tick();
      chk("a_wen_1cyc", bus.RfWriteEn, 0);
      chk("a_data_idle", bus.RfDataIn, 0);
      nxt();

      // register 7 passes untouched
      alu(1, 4'd7, 8'hFF); exp_wr(4'd7, 8'hFF);
      tick();
      nxt(); alu(0, 0, 0);
      tick();
      chk("r7_wen", bus.RfWriteEn, 1);
      nxt();

      // immediate load with a competing ALU request
      imm(1, 4'd5, 8'h81); alu(1, 4'd9, 8'h33); exp_wr(4'd9, 8'h33);
      tick();
      chk("i_imm_rdy", bus.ImmReady, 1);
      chk("i_alu_blk", bus.AluReady, 0);
      chk("i_pend",    bus.Pending, 16'h0020);
      nxt(); imm(0, 0, 0);
      tick();
      chk("i_set_regset", bus.RfRegSet, 1);
      chk("i_set_raddrb", bus.RfRaddrB, 5);
      chk("i_set_wen",    bus.RfWriteEn, 0);
      chk("i_set_alu",    bus.AluReady, 0);
      chk("i_set_imm",    bus.ImmReady, 0);
      chk("i_set_pend",   bus.Pending, 16'h0020);
      nxt();
      tick();
      chk("i_dat_regset", bus.RfRegSet, 0);
      chk("i_dat_data",   bus.RfDataIn, 8'h81);
      chk("i_dat_wen",    bus.RfWriteEn, 0);
      chk("i_dat_alu",    bus.AluReady, 0);
      chk("i_dat_pend",   bus.Pending, 0);
      nxt();
      tick();
      chk("i_idle_alu", bus.AluReady, 1);
      nxt(); alu(0, 0, 0);
      tick();
      chk("i_raddrb_hold", bus.RfRaddrB, 5);
      nxt();

      // memory returns fill the queue behind an immediate load, ALU waits behind them
      imm(1, 4'hC, 8'h3C);
      tick();
      chk("q_imm_rdy", bus.ImmReady, 1);
      nxt(); imm(0, 0, 0); mem(1, 4'd1, 8'h21); exp_wr(4'd1, 8'h21);
      tick();
      chk("q_regset",  bus.RfRegSet, 1);
      chk("q_mrdy1",   bus.MemReady, 1);
      nxt(); mem(1, 4'd2, 8'h22); exp_wr(4'd2, 8'h22);
      tick();
      chk("q_imm_data", bus.RfDataIn, 8'h3C);
      chk("q_mrdy2",    bus.MemReady, 1);
      chk("q_pend2",    bus.Pending, 16'h0006);
      nxt(); mem(1, 4'd4, 8'h24); exp_wr(4'd4, 8'h24); alu(1, 4'hA, 8'hAA); exp_wr(4'hA, 8'hAA);
      tick();
      chk("q_mem_full", bus.MemReady, 0);
      chk("q_alu_blk3", bus.AluReady, 0);
      chk("q_pend3",    bus.Pending, 16'h0006);
      nxt();
      tick();
      chk("q_mrdy_pop", bus.MemReady, 1);
      chk("q_alu_blk4", bus.AluReady, 0);
      chk("q_pend4",    bus.Pending, 16'h0014);
      nxt(); mem(0, 0, 0);
      tick();
      chk("q_alu_blk5", bus.AluReady, 0);
      nxt();
      tick();
      chk("q_alu_go", bus.AluReady, 1);
      nxt(); alu(0, 0, 0);
      tick();
      nxt();
      chk("q_sb_drained", sb.size(), 0);

      // overlapping writes to one register keep its pending bit up
      alu(1, 4'd5, 8'h55); mem(1, 4'd5, 8'h56); exp_wr(4'd5, 8'h55); exp_wr(4'd5, 8'h56);
      tick();
      chk("o_pend_acc", bus.Pending, 16'h0020);
      nxt(); alu(0, 0, 0); mem(0, 0, 0);
      tick();
      chk("o_pend_mid", bus.Pending, 16'h0020);
      nxt();
      tick();
      chk("o_pend_clr", bus.Pending, 0);
      nxt();

      // handshakes during Start are dropped
      Start = 1'b1; alu(1, 4'hB, 8'hBB); mem(1, 4'hC, 8'hCC);
      tick();
      chk("s_alu_rdy", bus.AluReady, 0);
      chk("s_mem_rdy", bus.MemReady, 0);
      nxt(); Start = 1'b0; alu(0, 0, 0); mem(0, 0, 0);
      tick();
      chk("s_pend", bus.Pending, 0);
      chk("s_wen",  bus.RfWriteEn, 0);
      nxt();
      tick();
      chk("s_wen2", bus.RfWriteEn, 0);
      nxt();

      // reset while in IMM_SET abandons the load
      imm(1, 4'd6, 8'h66);
      tick();
      nxt(); imm(0, 0, 0); Reset = 1'b1;
      tick();
      chk("r_regset_now", bus.RfRegSet, 1);
      chk("r_alu_rdy", bus.AluReady, 0);
      chk("r_imm_rdy", bus.ImmReady, 0);
      chk("r_mem_rdy", bus.MemReady, 0);
      nxt(); Reset = 1'b0;
      tick();
      chk("r_regset", bus.RfRegSet, 0);
      chk("r_pend",   bus.Pending, 0);
      chk("r_data",   bus.RfDataIn, 0);
      chk("r_raddrb", bus.RfRaddrB, 0);
      chk("r_idle",   bus.AluReady, 1);
      nxt();
      tick();
      chk("r_data2", bus.RfDataIn, 0);
      chk("r_wen2",  bus.RfWriteEn, 0);
      nxt();

`ifdef WB_FWD_EN
      bus.FwdAddr = 4'd2; mem(1, 4'd2, 8'h11); exp_wr(4'd2, 8'h11);
      tick();
      chk("f_hit_push",  bus.FwdHit, 1);
      chk("f_data_push", bus.FwdData, 8'h11);
      nxt(); mem(0, 0, 0);
      tick();
      chk("f_hit_q",  bus.FwdHit, 1);
      chk("f_data_q", bus.FwdData, 8'h11);
      bus.FwdAddr = 4'd6;
      #1;
      chk("f_miss", bus.FwdHit, 0);
      nxt();
      tick();
      nxt();
`endif

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
